wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Two-master round-robin Wishbone arbiter. It shares one Wishbone slave, the on-chip wb_ram,
//  between the CPU instruction port (m0) and the data/DMA port (m1).
//  Grant is registered and held for the whole cycle (cyc high), so bursts are never split.
//  Slave-side signals are muxed from the granted master. Ack/err return only to that master.
// PARAMETERS
//  ADDR_WIDTH      32  address width passed through to slave
//  DATA_WIDTH      32  data width (sel width = DATA_WIDTH/8)
//  TIMEOUT_CYCLES  256 stalled-cycle limit; used only with WB_ARB_TIMEOUT_EN
// PORTS
//  clk_i        in   1    system clock, all state on posedge
//  rst_ni       in   1    asynchronous, active-low reset
//  mN_adr_i     in   32   master N address (N=0,1; same for all mN_ ports)
//  mN_dat_i     in   32   master N write data
//  mN_dat_o     out  32   read data to master N (slave dat_o, unqualified)
//  mN_we_i      in   1    master N write enable
//  mN_sel_i     in   4    master N byte selects
//  mN_stb_i     in   1    master N strobe
//  mN_cyc_i     in   1    master N cycle request
//  mN_cti_i     in   3    master N cycle type
//  mN_bte_i     in   2    master N burst type
//  mN_ack_o     out  1    ack to master N (slave ack_o gated by grant)
//  mN_err_o     out  1    bus error to master N (0 unless WB_ARB_TIMEOUT_EN)
//  s_adr_o/s_dat_o/s_we_o/s_sel_o/s_stb_o/s_cyc_o/s_cti_o/s_bte_o  out  to slave, from granted master
//  s_dat_i      in   32   slave read data
//  s_ack_i      in   1    slave ack
//  gnt_o        out  2    one-hot grant {m1,m0}; 2'b00 = idle
// BEHAVIOUR
//  - States: IDLE, GNT0, GNT1 (registered). Reset: IDLE, gnt_o=0, last_gnt=1 (m0 wins first tie).
//  - IDLE: neither cyc -> IDLE; one cyc -> grant that master; both -> grant !last_gnt.
//  - GNTn: hold while mN_cyc_i=1, regardless of cti/stb. On mN_cyc_i=0, go to GNT(other) if
//    other cyc=1, else IDLE. last_gnt<=n on leaving GNTn.
//  - Latency: cyc rise in IDLE -> grant next clock. Slave sees cyc/stb that clock, combinationally.
//  - Slave outputs when IDLE: cyc=0, stb=0, we=0, all others 0. Never forward the ungranted master.
//  - mN_ack_o = s_ack_i & gnt_o[N]. Ungranted master: ack=0, err=0. mN_dat_o = s_dat_i for both.
//  - A master granted mid-cycle sees no ack until its own stb is forwarded. An ungranted master
//    simply stalls, with no protocol violation.
//  - Simultaneous release of current and request of other: handover with no IDLE cycle.
//  - Async reset mid-transfer: gnt_o, s_cyc_o, s_stb_o, acks and errs drop immediately. No transfer resumes.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//  - Counter clears on grant change or s_ack_i. It increments each cycle the granted stb=1 and ack=0.
//  - At TIMEOUT_CYCLES-1: pulse mN_err_o for 1 cycle, force state to IDLE, set last_gnt=n.
//    The other master then wins the next tie.
//  WB_ARB_TIMEOUT_EN undefined: no counter, mN_err_o tied 0, grant held indefinitely.
// STRUCTURE
//  - Shared package wb_arb_pkg: state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2),
//    CTI_END_OF_BURST=3'b111, CTI_INCR=3'b010, default widths.
//  - One sub-module wb_arb_timeout (counter + err pulse), instantiated only under WB_ARB_TIMEOUT_EN.
//  - Mux and FSM live in this file.
// TESTING
//  1. m0 cyc/stb write 0xDEADBEEF @0x10, m1 idle -> gnt_o=01 next clk, s_we_o=1, m0_ack_o=1, m1_ack_o=0.
//     A read-back of 0x10 returns 0xDEADBEEF.
//  2. After reset both cyc rise same clk -> m0 granted first. m0 drops cyc -> gnt_o=10 next clk,
//     no IDLE gap.
//  3. Continuous both-request, single-beat cycles -> grants alternate 01,10,01,10. Over 8 cycles each gets 4.
//  4. m1 4-beat burst (cti 010,010,010,111) @0x100 while m0 requests -> gnt_o stays 10 for all 4 acks.
//     m0 is granted only after m1 cyc drops.
//  5. rst_ni low mid-burst -> same-cycle gnt_o=00, s_cyc_o=0, acks=0. After release, state=IDLE.
//  6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave ack forced 0 -> m0_err_o single pulse on the 8th
//     stalled cycle, then gnt_o=00. A pending m1 is granted next.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared state encoding, Wishbone cycle-type codes and default widths for the
// two-master round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_INCR         = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    localparam int unsigned ADDR_WIDTH_DEF     = 32;
    localparam int unsigned DATA_WIDTH_DEF     = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the arbiter: counts cycles the granted strobe waits without
// an ack and flags expiry on the last allowed cycle.
module wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] gnt_i,
    input  logic       stb_i,
    input  logic       ack_i,
    output logic       expire_o
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       gnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_cur;

    // A grant that differs from last cycle's starts a fresh count this very cycle.
    assign cnt_cur  = (gnt_i != gnt_q) ? '0 : cnt_q;
    assign expire_o = (gnt_i != 2'b00) && stb_i && !ack_i && (cnt_cur == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            gnt_q <= gnt_i;
            if (ack_i || expire_o) begin
                cnt_q <= '0;
            end else if (stb_i) begin
                cnt_q <= cnt_cur + 1'b1;
            end else begin
                cnt_q <= cnt_cur;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing wb_ram between m0 and m1.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog and bus-error pulse.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    input  logic [2:0]              m0_cti_i,
    input  logic [1:0]              m0_bte_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,

    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    input  logic [2:0]              m1_cti_i,
    input  logic [1:0]              m1_bte_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,

    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    output logic [2:0]              s_cti_o,
    output logic [1:0]              s_bte_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,

    output logic [1:0]              gnt_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e state_q;
    logic       last_gnt_q;
    logic       expire;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .gnt_i    (gnt_o),
        .stb_i    (s_stb_o),
        .ack_i    (s_ack_i),
        .expire_o (expire)
    );
    assign m0_err_o = expire & gnt_o[0];
    assign m1_err_o = expire & gnt_o[1];
`else
    assign expire   = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    // Grant is held for the whole cyc so bursts never split; a release hands
    // straight over to a waiting master without an idle cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gnt_o      <= 2'b00;
            last_gnt_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                        state_q <= GNT0;
                        gnt_o   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q <= GNT1;
                        gnt_o   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (expire || !m0_cyc_i) begin
                        last_gnt_q <= 1'b0;
                        if (!expire && m1_cyc_i) begin
                            state_q <= GNT1;
                            gnt_o   <= 2'b10;
                        end else begin
                            state_q <= IDLE;
                            gnt_o   <= 2'b00;
                        end
                    end
                end
                GNT1: begin
                    if (expire || !m1_cyc_i) begin
                        last_gnt_q <= 1'b1;
                        if (!expire && m0_cyc_i) begin
                            state_q <= GNT0;
                            gnt_o   <= 2'b01;
                        end else begin
                            state_q <= IDLE;
                            gnt_o   <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_o   <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        if (gnt_o[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (gnt_o[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & gnt_o[0];
    assign m1_ack_o = s_ack_i & gnt_o[1];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a small RAM slave and read/grant scoreboards.
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [2:0]  m0_cti, m1_cti, s_cti;
    logic [1:0]  m0_bte, m1_bte, s_bte, gnt;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic        s_we, s_stb, s_cyc, s_ack, ack_en;

    logic [31:0] mem [256];
    assign s_ack  = s_cyc & s_stb & ack_en;
    assign s_rdat = mem[s_adr[9:2]];
    always @(posedge clk) begin
        if (s_ack && s_we) mem[s_adr[9:2]] <= s_wdat;
    end

    wb_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_cti_i(m0_cti),
        .m0_bte_i(m0_bte), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_cti_i(m1_cti),
        .m1_bte_i(m1_bte), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_cti_o(s_cti), .s_bte_o(s_bte),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rd_q [$];
    logic [1:0]  exp_gnt_q [$];
    logic [1:0]  exp_g;
    int          n0, n1;
    bit          a0, a1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_rd(input string tag, input logic [31:0] obs);
        check({tag, "_avail"}, (exp_rd_q.size() != 0), 1);
        if (exp_rd_q.size() != 0) check(tag, obs, exp_rd_q.pop_front());
    endtask

    task automatic drive_m0(input logic cyc, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [2:0] cti);
        m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_wdat = dat;
        m0_cti = cti; m0_sel = 4'hF; m0_bte = 2'b00;
    endtask

    task automatic drive_m1(input logic cyc, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [2:0] cti);
        m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_wdat = dat;
        m1_cti = cti; m1_sel = 4'hF; m1_bte = 2'b00;
    endtask

    task automatic idle_all();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ack_en = 1'b1;
        rst_n  = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_scyc", s_cyc, 0);
        check("rst_sstb", s_stb, 0);
        check("rst_swe", s_we, 0);
        check("rst_sadr", s_adr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: single m0 write then read-back.
        drive_m0(1, 1, 32'h10, 32'hDEADBEEF, CTI_END_OF_BURST);
        #1;
        check("t1_gnt_pre", gnt, 2'b00);
        check("t1_scyc_pre", s_cyc, 0);
        @(posedge clk); #1;
        check("t1_gnt", gnt, 2'b01);
        check("t1_swe", s_we, 1);
        check("t1_sadr", s_adr, 32'h10);
        check("t1_sdat", s_wdat, 32'hDEADBEEF);
        check("t1_m0ack", m0_ack, 1);
        check("t1_m1ack", m1_ack, 0);
        check("t1_m0err", m0_err, 0);
        @(posedge clk); #1;
        drive_m0(1, 0, 32'h10, 32'h0, CTI_END_OF_BURST);
        exp_rd_q.push_back(32'hDEADBEEF);
        #1;
        check("t1_rd_ack", m0_ack, 1);
        pop_rd("t1_rd", m0_rdat);
        check("t1_m1dat", m1_rdat, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive_m0(0, 0, 32'h0, 32'h0, 3'b000);
        @(posedge clk); #1;
        check("t1_idle", gnt, 2'b00);

        // Test 2: simultaneous request after reset, handover without idle gap.
        do_reset();
        drive_m0(1, 0, 32'h10, 32'h0, CTI_END_OF_BURST);
        drive_m1(1, 0, 32'h14, 32'h0, CTI_END_OF_BURST);
        exp_rd_q.push_back(32'hDEADBEEF);
        @(posedge clk); #1;
        check("t2_gnt0", gnt, 2'b01);
        check("t2_m0ack", m0_ack, 1);
        check("t2_m1ack", m1_ack, 0);
        check("t2_sadr", s_adr, 32'h10);
        pop_rd("t2_rd", m0_rdat);
        drive_m0(0, 0, 32'h0, 32'h0, 3'b000);
        #1;
        check("t2_no_fwd_cyc", s_cyc, 0);
        check("t2_no_fwd_adr", s_adr, 0);
        @(posedge clk); #1;
        check("t2_gnt1", gnt, 2'b10);
        check("t2_m1ack", m1_ack, 1);
        check("t2_sadr1", s_adr, 32'h14);
        drive_m1(0, 0, 32'h0, 32'h0, 3'b000);
        @(posedge clk); #1;
        check("t2_idle", gnt, 2'b00);

        // Test 3: continuous requests from both, single-beat cycles alternate.
        drive_m0(1, 0, 32'h20, 32'h0, CTI_END_OF_BURST);
        drive_m1(1, 0, 32'h24, 32'h0, CTI_END_OF_BURST);
        for (int i = 0; i < 8; i++) exp_gnt_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
        n0 = 0; n1 = 0; a0 = 0; a1 = 0;
        for (int c = 0; c < 64 && exp_gnt_q.size() != 0; c++) begin
            @(posedge clk); #1;
            m0_cyc = !a0; m0_stb = !a0;
            m1_cyc = !a1; m1_stb = !a1;
            #1;
            a0 = m0_ack; a1 = m1_ack;
            if (a0 || a1) begin
                exp_g = exp_gnt_q.pop_front();
                check($sformatf("t3_gnt%0d", n0 + n1), gnt, exp_g);
                if (a0) n0++;
                if (a1) n1++;
            end
        end
        check("t3_pending", exp_gnt_q.size(), 0);
        check("t3_m0_count", n0, 4);
        check("t3_m1_count", n1, 4);
        @(posedge clk); #1;
        idle_all();
        @(posedge clk); #1;
        check("t3_idle", gnt, 2'b00);

        // Test 4: m1 4-beat burst holds the grant while m0 waits.
        drive_m1(1, 1, 32'h100, 32'hB0000000, CTI_INCR);
        @(posedge clk); #1;
        drive_m0(1, 0, 32'h10, 32'h0, CTI_END_OF_BURST);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                @(posedge clk); #1;
                drive_m1(1, 1, 32'h100 + 32'(4 * b), 32'hB0000000 + 32'(b),
                         (b == 3) ? CTI_END_OF_BURST : CTI_INCR);
            end
            #1;
            check($sformatf("t4_gnt_b%0d", b), gnt, 2'b10);
            check($sformatf("t4_m1ack_b%0d", b), m1_ack, 1);
            check($sformatf("t4_m0ack_b%0d", b), m0_ack, 0);
            check($sformatf("t4_cti_b%0d", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
        end
        @(posedge clk); #1;
        drive_m1(0, 0, 32'h0, 32'h0, 3'b000);
        exp_rd_q.push_back(32'hDEADBEEF);
        #1;
        check("t4_hold_gnt", gnt, 2'b10);
        check("t4_hold_m0ack", m0_ack, 0);
        @(posedge clk); #1;
        check("t4_gnt_m0", gnt, 2'b01);
        check("t4_m0ack", m0_ack, 1);
        pop_rd("t4_rd0", m0_rdat);
        drive_m0(1, 0, 32'h10C, 32'h0, CTI_END_OF_BURST);
        exp_rd_q.push_back(32'hB0000003);
        #1;
        pop_rd("t4_rd_burst", m0_rdat);
        @(posedge clk); #1;
        drive_m0(0, 0, 32'h0, 32'h0, 3'b000);
        @(posedge clk); #1;
        check("t4_idle", gnt, 2'b00);

        // Test 5: asynchronous reset in the middle of an m1 burst.
        drive_m1(1, 1, 32'h200, 32'h55, CTI_INCR);
        @(posedge clk); #1;
        check("t5_gnt_pre", gnt, 2'b10);
        check("t5_m1ack_pre", m1_ack, 1);
        rst_n = 1'b0;
        #1;
        check("t5_gnt", gnt, 2'b00);
        check("t5_scyc", s_cyc, 0);
        check("t5_sstb", s_stb, 0);
        check("t5_m1ack", m1_ack, 0);
        check("t5_m0ack", m0_ack, 0);
        check("t5_m1err", m1_err, 0);
        idle_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_post_gnt", gnt, 2'b00);
        check("t5_post_scyc", s_cyc, 0);
        drive_m0(1, 0, 32'h10, 32'h0, CTI_END_OF_BURST);
        drive_m1(1, 0, 32'h14, 32'h0, CTI_END_OF_BURST);
        @(posedge clk); #1;
        check("t5_tie_m0", gnt, 2'b01);
        idle_all();
        @(posedge clk); #1;
        @(posedge clk); #1;

`ifdef WB_ARB_TIMEOUT_EN
        // Test 6: stalled slave, watchdog error pulse and handover to m1.
        ack_en = 1'b0;
        drive_m0(1, 0, 32'h20, 32'h0, CTI_END_OF_BURST);
        @(posedge clk); #1;
        drive_m1(1, 0, 32'h24, 32'h0, CTI_END_OF_BURST);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            #1;
            check($sformatf("t6_gnt_c%0d", c), gnt, 2'b01);
            check($sformatf("t6_m0err_c%0d", c), m0_err, (c == 8));
            check($sformatf("t6_m1err_c%0d", c), m1_err, 0);
            check($sformatf("t6_m0ack_c%0d", c), m0_ack, 0);
        end
        @(posedge clk); #1;
        check("t6_idle", gnt, 2'b00);
        check("t6_err_drop", m0_err, 0);
        @(posedge clk); #1;
        check("t6_gnt_m1", gnt, 2'b10);
        idle_all();
        ack_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
